matrix_spike_encoder: RTL
=========================

Name: matrix_spike_encoder

Overview:
- Scans a spike matrix in on-chip memory (one 16-bit word per neuron, nonzero = fired) after the LIF stage has written it.
- Emits one address-event (row, col) per fired neuron on a valid/ready stream toward the downstream synapse/accumulate stage.
- Traversal order and start/done control match the LIF matrix writer, so encoder addresses line up one-to-one with LIF output addresses.

Parameters:
ADDR_W, 14, memory address width
DATA_W, 16, memory word width
DIM_W, 10, row/col index and size width
CNT_W, 14, event counter width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  begin scan; sampled only while idle
done  out  1  high while idle; low from the cycle after start is accepted until the scan has fully drained
src_start_address  in  ADDR_W  base address of the spike matrix
src_address  out  ADDR_W  memory read address
src_readdata  in  DATA_W  memory read data, valid exactly 1 cycle after src_address
src_write_en  out  1  tied 0
row_size  in  DIM_W  rows; inner (fastest) index
col_size  in  DIM_W  columns; outer index
event_valid  out  1  event present
event_ready  in  1  downstream accepts the event
event_row  out  DIM_W  row index of the fired neuron
event_col  out  DIM_W  col index of the fired neuron
event_count  out  CNT_W  events handed off in the current or last scan

Behaviour:
- Reset values:
  - done=1, event_valid=0, src_address=src_start_address.
  - event_row=0, event_col=0, event_count=0, FSM=IDLE, FIFO empty.
- States:
  - IDLE: done=1; src_address follows src_start_address.
    - start=1 → done=0, event_count=0, row/col counters=0, go to SCAN.
    - Exception: row_size==0 or col_size==0 → go to DRAIN; no reads are issued.
  - SCAN: issue one read per cycle, src_address = src_start_address + col*row_size + row, i.e. linear increment.
    - Row increments first; on row==row_size-1, row resets to 0 and col increments.
    - After issuing (row_size-1, col_size-1), go to DRAIN.
  - DRAIN: wait for the final in-flight read to be classified and the FIFO to empty → IDLE (done=1 the next cycle).
- Read pipeline:
  - The (row, col) tag of each issued address is registered for 1 cycle alongside the read.
  - On return, src_readdata != 0 pushes {row, col} into the 2-entry output FIFO; zero words are dropped.
- Backpressure:
  - Issue in SCAN is gated by the FIFO: issue only when the FIFO will have a free slot for the in-flight read (count<1, or count==1 with a pop this cycle).
  - No read result is ever lost or duplicated.
  - While stalled, src_address holds.
- Throughput: one matrix element per cycle when event_ready=1.
- Output stream:
  - event_valid reflects FIFO non-empty; event_row/col come from the FIFO head.
  - Handshake completes when valid && ready. event_row/col hold stable while valid && !ready.
  - event_count increments on each handshake and saturates at all-ones.
- Latency: from start accepted, a spike at linear index k appears on event_valid no earlier than cycle k+3.
- start asserted while not IDLE is ignored.
- Sizes and src_start_address are sampled only in IDLE on start; mid-scan changes are ignored.
- Reset mid-scan: aborts immediately, flushes the FIFO and in-flight read, all outputs return to reset values.
- Address arithmetic is modulo 2^ADDR_W; no bounds check.

Decomposition:
- Shared package snn_pkg holds:
  - state encoding (IDLE, SCAN, DRAIN)
  - width constants ADDR_W, DATA_W, DIM_W, CNT_W
  - event type {row, col}
- One sub-module: spike_event_fifo, a 2-entry synchronous FIFO/skid buffer with push, pop, full, empty and count.

Test Plan:
- 3x2 matrix, base 100, words at addr 101 and 105 = 1, rest 0, ready=1 → events (1,0) then (2,1); event_count=2; done returns 1; src_address covers 100..105 exactly once.
- Same matrix, event_ready toggled 1-0-0-1 → identical event sequence; event_row/col stable while stalled; no duplicates.
- 4x4 all-zero matrix → no event_valid; 16 reads; done back to 1; event_count=0.
- 4x4 all-ones (nonzero 0x8000 included), ready=1 → 16 events in row-major-inner order (0,0),(1,0)…(3,3), at one per cycle after the pipeline fills.
- row_size=0, start → done low, then high within 2 cycles; no reads, no events.
- Reset asserted on cycle 5 of a 4x4 all-ones scan with ready=0 → next cycle event_valid=0, done=1, event_count=0; a new start rescans from (0,0).

Source files
------------

// File: rtl/snn_pkg.sv
// Shared types and widths for the spike encoder: FSM states, bus widths and the
// address-event record carried on the output stream.
package snn_pkg;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 16;
  localparam int DIM_W  = 10;
  localparam int CNT_W  = 14;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN
  } state_t;

  typedef struct packed {
    logic [DIM_W-1:0] row;
    logic [DIM_W-1:0] col;
  } event_t;

endpackage

// File: rtl/matrix_spike_encoder_if.sv
// Address-event output stream: valid/ready handshake carrying one (row, col) per fired neuron.
interface matrix_spike_encoder_if
  import snn_pkg::*;
();

  logic             event_valid;
  logic             event_ready;
  logic [DIM_W-1:0] event_row;
  logic [DIM_W-1:0] event_col;

  modport master (
    output event_valid,
    output event_row,
    output event_col,
    input  event_ready
  );

  modport slave (
    input  event_valid,
    input  event_row,
    input  event_col,
    output event_ready
  );

endinterface

// File: rtl/spike_event_fifo.sv
// Two-entry synchronous FIFO used as the output skid buffer; a push is accepted
// when full only if the head is popped in the same cycle.
module spike_event_fifo
  import snn_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  event_t     push_data,
  input  logic       pop,
  output event_t     head,
  output logic       full,
  output logic       empty,
  output logic [1:0] count
);

  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       do_push, do_pop;
  event_t     mem_q [2];

  assign full    = (count_q == 2'd2);
  assign empty   = (count_q == 2'd0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q ^ do_push;
    rd_ptr_d = rd_ptr_q ^ do_pop;
    count_d  = count_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/matrix_spike_encoder.sv
// Scans a spike matrix (row fastest, then col) and emits one (row, col) event per
// nonzero word; reads are throttled so the returning word always has a FIFO slot.
module matrix_spike_encoder
  import snn_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              done,
  input  logic [ADDR_W-1:0] src_start_address,
  output logic [ADDR_W-1:0] src_address,
  input  logic [DATA_W-1:0] src_readdata,
  output logic              src_write_en,
  input  logic [DIM_W-1:0]  row_size,
  input  logic [DIM_W-1:0]  col_size,
  matrix_spike_encoder_if.master ev,
  output logic [CNT_W-1:0]  event_count
);

  state_t            state_q, state_d;
  logic [DIM_W-1:0]  row_q, row_d, col_q, col_d;
  logic [DIM_W-1:0]  rows_q, rows_d, cols_q, cols_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_vld_q, rd_vld_d;
  event_t            tag_q, tag_d;
  logic [CNT_W-1:0]  event_count_q, event_count_d;

  logic       issue, handshake, slot_free;
  logic       fifo_push, fifo_full, fifo_empty;
  logic [1:0] fifo_count;
  event_t     fifo_head;

  assign handshake = ev.event_valid && ev.event_ready;
  // The read issued now lands next cycle while last cycle's read lands now, so at most one entry may be held.
  assign slot_free = (fifo_count == 2'd0) || (!fifo_full && handshake);
  assign fifo_push = rd_vld_q && (src_readdata != '0);

  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    col_d         = col_q;
    rows_d        = rows_q;
    cols_d        = cols_q;
    addr_d        = addr_q;
    event_count_d = event_count_q;
    issue         = 1'b0;
    tag_d         = '{row: row_q, col: col_q};

    if (handshake && (event_count_q != '1)) event_count_d = event_count_q + CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          event_count_d = '0;
          row_d         = '0;
          col_d         = '0;
          rows_d        = row_size;
          cols_d        = col_size;
          addr_d        = src_start_address;
          state_d       = ((row_size == '0) || (col_size == '0)) ? ST_DRAIN : ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (slot_free) begin
          issue  = 1'b1;
          addr_d = addr_q + ADDR_W'(1);
          if (row_q == rows_q - DIM_W'(1)) begin
            row_d = '0;
            if (col_q == cols_q - DIM_W'(1)) state_d = ST_DRAIN;
            else                             col_d   = col_q + DIM_W'(1);
          end else begin
            row_d = row_q + DIM_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (!rd_vld_q && fifo_empty) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    rd_vld_d = issue;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      row_q         <= '0;
      col_q         <= '0;
      rows_q        <= '0;
      cols_q        <= '0;
      addr_q        <= '0;
      rd_vld_q      <= 1'b0;
      tag_q         <= '0;
      event_count_q <= '0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      col_q         <= col_d;
      rows_q        <= rows_d;
      cols_q        <= cols_d;
      addr_q        <= addr_d;
      rd_vld_q      <= rd_vld_d;
      tag_q         <= tag_d;
      event_count_q <= event_count_d;
    end
  end

  spike_event_fifo u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (tag_q),
    .pop       (handshake),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign done           = (state_q == ST_IDLE);
  assign src_address    = (state_q == ST_IDLE) ? src_start_address : addr_q;
  assign src_write_en   = 1'b0;
  assign event_count    = event_count_q;
  assign ev.event_valid = !fifo_empty;
  assign ev.event_row   = fifo_head.row;
  assign ev.event_col   = fifo_head.col;

endmodule
